merge_n_alu_hs: RTL and testbench
=================================

// Module: merge_n_alu_hs
// PURPOSE
//  Clocked N-channel request merge onto the single shared ALU handshake port.
//  Each channel presents req/ack (4-phase, return-to-zero) plus a 7-bit opcode.
//  One requester is granted per transaction: round-robin, or load-class priority.
//  Illegal opcodes are acked and drained locally; they never reach the ALU.
//  Sits between issue channels and the ALU; generalises the 2-input opcode-steered merge.
// PARAMETERS
//  N_CH           4    number of requester channels (2..16)
//  PRIO_LD        0    1: I_TYPE_LD requests beat R_TYPE requests; round-robin within a class
//  TIMEOUT_CYCLES 256  ALU ack watchdog limit (used only with MERGE_TIMEOUT_EN)
// PORTS
//  clk         in   1              clock
//  rst_n       in   1              synchronous reset, active-low
//  req_in      in   N_CH           per-channel request
//  opcode_in   in   N_CH*7         per-channel opcode; channel i = [7*i+:7]
//  ack_out     out  N_CH           per-channel acknowledge
//  req_out     out  1              request to ALU
//  ack_in      in   1              ALU acknowledge
//  opcode_out  out  7              opcode of granted channel; stable while req_out=1
//  grant_idx   out  $clog2(N_CH)   granted channel; valid outside IDLE
//  illegal_op  out  1              1-cycle pulse when an illegal opcode is drained
//  timeout_err out  1              sticky watchdog flag; tied 0 without the macro
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - All outputs go to 0; FSM to IDLE; round-robin pointer to 0.
//   - Reset mid-handshake abandons the transaction; requesters restart from req=0.
//  Timing and eligibility:
//   - All inputs are clk-synchronous; no synchronisers in this block.
//   - All outputs are registered.
//   - Eligible channel: req_in[i]=1 and ack_out[i]=0.
//  FSM (one transaction at a time):
//   - IDLE: arbitrate among eligible channels; latch g, opcode_in[g]; grant_idx<=g.
//       Legal opcode -> REQ, req_out<=1.
//       Illegal opcode -> DROP, ack_out[g]<=1, illegal_op pulse.
//   - REQ: hold req_out=1; ack_in=1 -> ACK, ack_out[g]<=1.
//   - ACK: req_in[g]=0 -> RTZ, req_out<=0.
//   - RTZ: ack_in=0 -> IDLE, ack_out[g]<=0; pointer<=g+1 mod N_CH.
//   - DROP: req_in[g]=0 -> IDLE, ack_out[g]<=0; pointer<=g+1 mod N_CH.
//  Latency:
//   - req_in[g] rise to req_out rise: 1 cycle.
//   - ack_in edge to ack_out[g] edge: 1 cycle.
//   - Minimum transaction: 4 cycles from IDLE back to IDLE.
//  Arbitration:
//   - Performed only in IDLE.
//   - Search starts at the pointer and wraps N_CH-1 -> 0.
//   - PRIO_LD=1: the search runs first over I_TYPE_LD channels, then R_TYPE.
//  Simultaneous events and protocol violations:
//   - Non-granted channels are ignored until IDLE; their req may drop freely.
//   - req_in[g] falling during REQ (protocol violation) is ignored; FSM still waits for ack_in.
//   - ack_in=1 while in IDLE is ignored.
//  Opcodes: legal = R_TYPE 7'b0110011, I_TYPE_LD 7'b0000011; all others illegal.
// CONFIGURATION
//  MERGE_TIMEOUT_EN defined:
//   - Counter runs in REQ and RTZ; it clears on every state change.
//   - At TIMEOUT_CYCLES: timeout_err<=1 (sticky until reset), req_out<=0, ack_out[g]<=1,
//     FSM -> DROP; ack_in is then ignored until IDLE.
//  MERGE_TIMEOUT_EN undefined: no counter; timeout_err constant 0; REQ/RTZ wait forever.
// STRUCTURE
//  Package merge_pkg:
//   - opcode constants R_TYPE, I_TYPE_LD.
//   - state enum {IDLE,REQ,ACK,RTZ,DROP}.
//   - function is_legal_op().
//  Sub-module rr_arbiter:
//   - Parameter N; inputs req[N], ptr; outputs gnt_idx, gnt_valid; purely combinational.
//   - Instantiated twice when PRIO_LD=1.
// TESTING
//  1. N_CH=4; ch2 req with R_TYPE; ALU acks after 3 cycles
//     -> req_out=1 next cycle; opcode_out=0110011; ack_out[2] follows ack_in by 1 cycle; full RZ.
//  2. ch0..3 all request together, PRIO_LD=0, pointer=0
//     -> grants in order 0,1,2,3; grant_idx sequence 0,1,2,3.
//  3. PRIO_LD=1; ch0 R_TYPE and ch3 I_TYPE_LD simultaneously -> ch3 granted first, then ch0.
//  4. ch1 opcode 7'h13 -> illegal_op 1-cycle pulse; ack_out[1]=1; req_out never rises.
//  5. rst_n=0 while in ACK -> next cycle req_out=0, ack_out=0, grant_idx=0; new request served normally.
//  6. MERGE_TIMEOUT_EN, TIMEOUT_CYCLES=8, ack_in held 0
//     -> after 8 cycles in REQ: timeout_err=1, req_out=0, ack_out[g]=1.

Source files
------------

// File: rtl/merge_pkg.sv
// Shared opcode constants, FSM state type and opcode legality check for the ALU request merge.
package merge_pkg;

  localparam logic [6:0] R_TYPE    = 7'b0110011;
  localparam logic [6:0] I_TYPE_LD = 7'b0000011;

  typedef enum logic [2:0] {IDLE, REQ, ACK, RTZ, DROP} state_e;

  function automatic logic is_legal_op(input logic [6:0] op);
    return (op == R_TYPE) || (op == I_TYPE_LD);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first set request at or after ptr, wrapping N-1 -> 0.
module rr_arbiter #(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);

  int unsigned idx;

  always_comb begin
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (32'(ptr) + k) % N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = ($clog2(N))'(idx);
      end
    end
  end

endmodule

// File: rtl/merge_n_alu_hs.sv
// N-channel 4-phase request merge onto one ALU handshake port; illegal opcodes drained locally.
// Optional ALU ack watchdog enabled by defining MERGE_TIMEOUT_EN.
module merge_n_alu_hs #(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned PRIO_LD        = 0,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_CH-1:0]         req_in,
  input  logic [N_CH*7-1:0]       opcode_in,
  output logic [N_CH-1:0]         ack_out,
  output logic                    req_out,
  input  logic                    ack_in,
  output logic [6:0]              opcode_out,
  output logic [$clog2(N_CH)-1:0] grant_idx,
  output logic                    illegal_op,
  output logic                    timeout_err
);
  import merge_pkg::*;

  localparam int unsigned IW = $clog2(N_CH);

  state_e          state_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   ptr_wrap;
  logic [N_CH-1:0] elig;
  logic [IW-1:0]   gnt_idx;
  logic            gnt_valid;
  logic [6:0]      op_sel;

  assign elig     = req_in & ~ack_out;
  assign ptr_wrap = (grant_idx == IW'(N_CH - 1)) ? '0 : grant_idx + 1'b1;

  if (PRIO_LD != 0) begin : g_prio
    logic [N_CH-1:0] ld_mask;
    logic [IW-1:0]   ld_idx, oth_idx;
    logic            ld_valid, oth_valid;

    always_comb begin
      ld_mask = '0;
      for (int i = 0; i < int'(N_CH); i++) ld_mask[i] = (opcode_in[7*i+:7] == I_TYPE_LD);
    end

    rr_arbiter #(.N(N_CH)) u_arb_ld (
      .req      (elig & ld_mask),
      .ptr      (ptr_q),
      .gnt_idx  (ld_idx),
      .gnt_valid(ld_valid)
    );
    rr_arbiter #(.N(N_CH)) u_arb_oth (
      .req      (elig & ~ld_mask),
      .ptr      (ptr_q),
      .gnt_idx  (oth_idx),
      .gnt_valid(oth_valid)
    );

    assign gnt_idx   = ld_valid ? ld_idx : oth_idx;
    assign gnt_valid = ld_valid | oth_valid;
  end else begin : g_rr
    rr_arbiter #(.N(N_CH)) u_arb (
      .req      (elig),
      .ptr      (ptr_q),
      .gnt_idx  (gnt_idx),
      .gnt_valid(gnt_valid)
    );
  end

  always_comb begin
    op_sel = '0;
    for (int i = 0; i < int'(N_CH); i++) begin
      if (gnt_idx == IW'(i)) op_sel = opcode_in[7*i+:7];
    end
  end

`ifdef MERGE_TIMEOUT_EN
  logic [$clog2(TIMEOUT_CYCLES+1)-1:0] cnt_q;
  logic                                tmo_hit;
  assign tmo_hit = (cnt_q == ($clog2(TIMEOUT_CYCLES+1))'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      ack_out    <= '0;
      req_out    <= 1'b0;
      opcode_out <= '0;
      grant_idx  <= '0;
      illegal_op <= 1'b0;
`ifdef MERGE_TIMEOUT_EN
      cnt_q       <= '0;
      timeout_err <= 1'b0;
`endif
    end else begin
      illegal_op <= 1'b0;
`ifdef MERGE_TIMEOUT_EN
      // Transitions out of REQ/RTZ below override this with a clear.
      cnt_q <= (state_q == REQ || state_q == RTZ) ? cnt_q + 1'b1 : '0;
`endif
      case (state_q)
        IDLE: begin
          if (gnt_valid) begin
            grant_idx  <= gnt_idx;
            opcode_out <= op_sel;
            if (is_legal_op(op_sel)) begin
              state_q <= REQ;
              req_out <= 1'b1;
            end else begin
              state_q          <= DROP;
              ack_out[gnt_idx] <= 1'b1;
              illegal_op       <= 1'b1;
            end
          end
        end
        REQ: begin
          if (ack_in) begin
            state_q            <= ACK;
            ack_out[grant_idx] <= 1'b1;
`ifdef MERGE_TIMEOUT_EN
            cnt_q <= '0;
          end else if (tmo_hit) begin
            state_q            <= DROP;
            req_out            <= 1'b0;
            ack_out[grant_idx] <= 1'b1;
            timeout_err        <= 1'b1;
            cnt_q              <= '0;
`endif
          end
        end
        ACK: begin
          if (!req_in[grant_idx]) begin
            state_q <= RTZ;
            req_out <= 1'b0;
          end
        end
        RTZ: begin
          if (!ack_in) begin
            state_q            <= IDLE;
            ack_out[grant_idx] <= 1'b0;
            ptr_q              <= ptr_wrap;
`ifdef MERGE_TIMEOUT_EN
            cnt_q <= '0;
          end else if (tmo_hit) begin
            state_q            <= DROP;
            ack_out[grant_idx] <= 1'b1;
            timeout_err        <= 1'b1;
            cnt_q              <= '0;
`endif
          end
        end
        DROP: begin
          if (!req_in[grant_idx]) begin
            state_q            <= IDLE;
            ack_out[grant_idx] <= 1'b0;
            ptr_q              <= ptr_wrap;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_n_alu_hs.sv
// Directed scoreboard bench for merge_n_alu_hs (N_CH=4, PRIO_LD=1).
module tb_merge_n_alu_hs;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_BAD = 7'h13;

  typedef struct {
    int         idx;
    logic [6:0] op;
    bit         bad;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic [3:0] req_in;
  logic [27:0] opcode_in;
  logic [3:0] ack_out;
  logic       req_out;
  logic       ack_in;
  logic [6:0] opcode_out;
  logic [1:0] grant_idx;
  logic       illegal_op;
  logic       timeout_err;

  int   n_tests = 0;
  int   n_fail  = 0;
  exp_t sb[$];

  merge_n_alu_hs #(
    .N_CH          (4),
    .PRIO_LD       (1),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_in     (req_in),
    .opcode_in  (opcode_in),
    .ack_out    (ack_out),
    .req_out    (req_out),
    .ack_in     (ack_in),
    .opcode_out (opcode_out),
    .grant_idx  (grant_idx),
    .illegal_op (illegal_op),
    .timeout_err(timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench time limit");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic request(input int ch, input logic [6:0] op);
    exp_t e;
    opcode_in[7*ch+:7] = op;
    req_in[ch] = 1'b1;
    e.idx = ch;
    e.op  = op;
    e.bad = !(op == OP_R || op == OP_LD);
    sb.push_back(e);
  endtask

  // Waits for the next grant, pops the scoreboard and completes the handshake as requester + ALU.
  task automatic do_txn(input int ack_delay);
    exp_t e;
    int   waited;
    bit   seen;
    seen   = 1'b0;
    waited = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (req_out || illegal_op) begin
        seen = 1'b1;
        break;
      end
      waited++;
    end
    chk("txn_seen", 32'(seen), 32'd1);
    if (!seen) return;
    chk("start_latency", 32'(waited), 32'd0);
    if (sb.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    chk("grant_idx", 32'(grant_idx), 32'(e.idx));
    if (e.bad) begin
      chk("illegal_pulse", 32'(illegal_op), 32'd1);
      chk("drop_ack", 32'(ack_out), 32'd1 << e.idx);
      chk("drop_no_req", 32'(req_out), 32'd0);
      @(negedge clk);
      chk("illegal_pulse_end", 32'(illegal_op), 32'd0);
      chk("drop_no_req2", 32'(req_out), 32'd0);
      req_in[e.idx] = 1'b0;
      @(negedge clk);
      chk("drop_ack_clear", 32'(ack_out), 32'd0);
    end else begin
      chk("opcode_out", 32'(opcode_out), 32'(e.op));
      chk("ack_wait", 32'(ack_out), 32'd0);
      repeat (ack_delay) @(negedge clk);
      chk("req_held", 32'(req_out), 32'd1);
      ack_in = 1'b1;
      @(negedge clk);
      chk("ack_follow", 32'(ack_out), 32'd1 << e.idx);
      chk("opcode_stable", 32'(opcode_out), 32'(e.op));
      req_in[e.idx] = 1'b0;
      @(negedge clk);
      chk("req_rtz", 32'(req_out), 32'd0);
      ack_in = 1'b0;
      @(negedge clk);
      chk("ack_rtz", 32'(ack_out), 32'd0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_in    = '0;
    opcode_in = '0;
    ack_in    = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_out", 32'(req_out), 32'd0);
    chk("rst_ack_out", 32'(ack_out), 32'd0);
    chk("rst_grant", 32'(grant_idx), 32'd0);
    chk("rst_opcode", 32'(opcode_out), 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    chk("rst_timeout", 32'(timeout_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single R_TYPE request on ch2, ALU acks after 3 cycles.
    request(2, OP_R);
    do_txn(3);

    // All four R_TYPE together; pointer is 3 after ch2, so order wraps 3,0,1,2.
    for (int i = 0; i < 4; i++) opcode_in[7*i+:7] = OP_R;
    request(3, OP_R);
    request(0, OP_R);
    request(1, OP_R);
    request(2, OP_R);
    for (int i = 0; i < 4; i++) do_txn(i);

    // Pointer 3 favours ch3, but the load on ch1 wins.
    request(3, OP_R);
    request(1, OP_LD);
    sb.delete();
    sb.push_back('{1, OP_LD, 1'b0});
    sb.push_back('{3, OP_R, 1'b0});
    do_txn(0);
    do_txn(1);

    // Pointer 0: ch0 R_TYPE vs ch3 load -> ch3 then ch0.
    request(0, OP_R);
    request(3, OP_LD);
    sb.delete();
    sb.push_back('{3, OP_LD, 1'b0});
    sb.push_back('{0, OP_R, 1'b0});
    do_txn(2);
    do_txn(0);

    // Illegal opcode drained locally.
    request(1, OP_BAD);
    do_txn(0);

    // ALU ack while idle is ignored.
    ack_in = 1'b1;
    repeat (2) @(negedge clk);
    chk("idle_ack_ignored_req", 32'(req_out), 32'd0);
    chk("idle_ack_ignored_ack", 32'(ack_out), 32'd0);
    ack_in = 1'b0;
    @(negedge clk);

    // Reset during ACK abandons the transaction.
    opcode_in[7+:7] = OP_R;
    req_in[1] = 1'b1;
    @(negedge clk);
    chk("t5_req_out", 32'(req_out), 32'd1);
    chk("t5_grant", 32'(grant_idx), 32'd1);
    ack_in = 1'b1;
    @(negedge clk);
    chk("t5_in_ack", 32'(ack_out), 32'd2);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t5_rst_req_out", 32'(req_out), 32'd0);
    chk("t5_rst_ack_out", 32'(ack_out), 32'd0);
    chk("t5_rst_grant", 32'(grant_idx), 32'd0);
    rst_n  = 1'b1;
    req_in = '0;
    ack_in = 1'b0;
    @(negedge clk);
    request(1, OP_R);
    do_txn(1);

`ifdef MERGE_TIMEOUT_EN
    // ALU never acks: watchdog fires after 8 cycles in REQ.
    request(0, OP_R);
    @(negedge clk);
    chk("t6_req_out", 32'(req_out), 32'd1);
    repeat (7) @(negedge clk);
    chk("t6_still_waiting", 32'(req_out), 32'd1);
    @(negedge clk);
    chk("t6_timeout_err", 32'(timeout_err), 32'd1);
    chk("t6_req_drop", 32'(req_out), 32'd0);
    chk("t6_ack_out", 32'(ack_out), 32'd1);
    void'(sb.pop_front());
    req_in[0] = 1'b0;
    @(negedge clk);
    chk("t6_ack_clear", 32'(ack_out), 32'd0);
    chk("t6_sticky", 32'(timeout_err), 32'd1);
`else
    chk("no_timeout_flag", 32'(timeout_err), 32'd0);
`endif

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
